// File: rtl/lsu.sv
// lsu: Eka memory-stage load/store unit -- request/grant/response bus, store lane steering, load extension.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses with lsu_err.
module lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_valid,
  input  logic              lsu_we,
  input  logic [2:0]        lsu_funct3,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_busy,
  output logic              lsu_done,
  output logic              lsu_err,
  output logic [31:0]       lsu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;
  logic              lsu_busy_q, lsu_done_q, lsu_err_q;
  logic [31:0]       lsu_rdata_q;

  logic              legal_d;
  logic [1:0]        lane_d;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d;
  logic [31:0]       shifted_d;
  logic [31:0]       rdata_d;

  // lane_d is the lowest byte lane the access touches; halfwords and words are
  // forced to their natural lane so unaligned low address bits are ignored.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    legal_d = 1'b0;
    lane_d  = 2'b00;
    be_d    = 4'b1111;
    wdata_d = lsu_wdata;
    case (lsu_funct3[1:0])
      2'b00: begin
        legal_d = !(lsu_we && lsu_funct3[2]);
        lane_d  = lsu_addr[1:0];
        be_d    = 4'b0001 << lane_d;
        wdata_d = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        legal_d = !(lsu_we && lsu_funct3[2]);
        lane_d  = {lsu_addr[1], 1'b0};
        be_d    = 4'b0011 << lane_d;
        wdata_d = {2{lsu_wdata[15:0]}};
      end
      2'b10: begin
        legal_d = !lsu_funct3[2];
      end
      default: begin
        legal_d = 1'b0;
      end
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    if ((lsu_funct3[1:0] == 2'b01 && lsu_addr[0]) ||
        (lsu_funct3[1:0] == 2'b10 && lsu_addr[1:0] != 2'b00)) begin
      legal_d = 1'b0;
    end
`endif
  end

  always_comb begin
    shifted_d = mem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  rdata_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
      3'b001:  rdata_d = {{16{shifted_d[15]}}, shifted_d[15:0]};
      3'b100:  rdata_d = {24'h000000, shifted_d[7:0]};
      3'b101:  rdata_d = {16'h0000, shifted_d[15:0]};
      default: rdata_d = shifted_d;
    endcase
  end

  // NOTE: asynchronous active-low reset; all state is updated with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      lsu_busy_q  <= 1'b0;
      lsu_done_q  <= 1'b0;
      lsu_err_q   <= 1'b0;
      lsu_rdata_q <= 32'h0;
    end else begin
      lsu_done_q <= 1'b0;
      lsu_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (lsu_valid) begin
            if (legal_d) begin
              state_q     <= REQ;
              we_q        <= lsu_we;
              funct3_q    <= lsu_funct3;
              lane_q      <= lane_d;
              mem_req_q   <= 1'b1;
              mem_we_q    <= lsu_we;
              mem_addr_q  <= {lsu_addr[ADDR_W-1:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
              lsu_busy_q  <= 1'b1;
            end else begin
              lsu_err_q <= 1'b1;
            end
          end
        end
        REQ: begin
          // A same-cycle rvalid is deliberately dropped; data is only taken in WAIT.
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (we_q) begin
              state_q    <= DONE;
              lsu_done_q <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            lsu_rdata_q <= rdata_d;
            state_q     <= DONE;
            lsu_done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          lsu_busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lsu_busy  = lsu_busy_q;
  assign lsu_done  = lsu_done_q;
  assign lsu_err   = lsu_err_q;
  assign lsu_rdata = lsu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized scoreboard bench for lsu; expected bus requests and responses are queued
// by the stimulus and compared by an independent negedge monitor.
module tb_lsu;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              lsu_valid, lsu_we;
  logic [2:0]        lsu_funct3;
  logic [ADDR_W-1:0] lsu_addr;
  logic [31:0]       lsu_wdata;
  logic              lsu_busy, lsu_done, lsu_err;
  logic [31:0]       lsu_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt, mem_rvalid;
  logic [31:0]       mem_rdata;

  lsu #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_err(lsu_err), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic        err;
    logic        is_load;
    logic [31:0] rdata;
  } resp_exp_t;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-level view of the access, computed with plain arithmetic.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd,
                                output logic legal, output bus_exp_t b, output resp_exp_t r);
    int size, first, nbytes;
    logic [31:0] mask, v;
    size  = int'(f3[1:0]);
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_TRAP_EN
    if ((size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0)) legal = 1'b0;
`endif
    first  = (size == 0) ? int'(addr % 4) : (size == 1) ? int'((addr % 4) / 2 * 2) : 0;
    nbytes = 1 << size;
    b.we    = we;
    b.addr  = addr & 32'hFFFF_FFFC;
    b.be    = 4'(((1 << nbytes) - 1) << first);
    b.wdata = (size == 0) ? (wd & 32'hFF) * 32'h0101_0101 :
              (size == 1) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    mask = (size == 0) ? 32'hFF : (size == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
    v    = (rd >> (8 * first)) & mask;
    if (!f3[2] && size < 2 && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
    r.err     = !legal;
    r.is_load = !we;
    r.rdata   = v;
  endfunction

  // Monitor: compares bus requests and responses against the queued expectations.
  logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_addr = 32'h0, prev_wdata = 32'h0;
  logic [3:0]  prev_be = 4'h0;
  bus_exp_t    mon_b;
  resp_exp_t   mon_r;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req && !prev_req) check("req_expected", 32'(bus_q.size() > 0), 32'd1);
      if (mem_req && prev_req && !prev_gnt) begin
        check("stable_addr", mem_addr, prev_addr);
        check("stable_be", 32'(mem_be), 32'(prev_be));
        check("stable_wdata", mem_wdata, prev_wdata);
        check("stable_we", 32'(mem_we), 32'(prev_we));
      end
      if (mem_req && mem_gnt && bus_q.size() > 0) begin
        mon_b = bus_q.pop_front();
        check("bus_we", 32'(mem_we), 32'(mon_b.we));
        check("bus_addr", mem_addr, mon_b.addr);
        check("bus_be", 32'(mem_be), 32'(mon_b.be));
        if (mon_b.we) check("bus_wdata", mem_wdata, mon_b.wdata);
      end
      if (lsu_done || lsu_err) begin
        if (resp_q.size() == 0) begin
          check("resp_expected", {30'h0, lsu_done, lsu_err}, 32'h0);
        end else begin
          mon_r = resp_q.pop_front();
          check("err_flag", 32'(lsu_err), 32'(mon_r.err));
          check("done_flag", 32'(lsu_done), 32'(!mon_r.err));
          if (!mon_r.err && mon_r.is_load) check("load_rdata", lsu_rdata, mon_r.rdata);
        end
      end
    end
    prev_req   = mem_req;
    prev_gnt   = mem_gnt;
    prev_we    = mem_we;
    prev_addr  = mem_addr;
    prev_be    = mem_be;
    prev_wdata = mem_wdata;
  end

  // Issue one access, play the bus with gw grant-wait and rw rvalid-wait cycles, and check timing.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int gw, input int rw);
    logic      legal, busy_ok;
    bus_exp_t  b;
    resp_exp_t r;
    int        lat_exp, lat, n, phase;
    model(we, f3, addr, wd, rd, legal, b, r);
    if (legal) bus_q.push_back(b);
    resp_q.push_back(r);
    lat_exp = !legal ? 1 : we ? 2 + gw : 3 + gw + rw;

    @(posedge clk); #1;
    lsu_valid  = 1'b1;
    lsu_we     = we;
    lsu_funct3 = f3;
    lsu_addr   = addr;
    lsu_wdata  = wd;
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    lat = 0; phase = 0; n = 0; busy_ok = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (lsu_done || lsu_err) begin
        lat = cyc;
        break;
      end
      if (lsu_busy !== legal) busy_ok = 1'b0;
      if (legal) begin
        // Junk requests while busy must be ignored.
        lsu_valid  = 1'b1;
        lsu_we     = 1'($urandom);
        lsu_funct3 = 3'($urandom);
        lsu_addr   = $urandom;
        lsu_wdata  = $urandom;
      end
      case (phase)
        0: begin
          mem_gnt    = (n >= gw);
          mem_rvalid = 1'($urandom_range(0, 1));
          mem_rdata  = $urandom;
          if (mem_gnt) begin
            phase = we ? 2 : 1;
            n = 0;
          end else begin
            n++;
          end
        end
        1: begin
          mem_gnt    = 1'b0;
          mem_rvalid = (n >= rw);
          mem_rdata  = mem_rvalid ? rd : $urandom;
          if (mem_rvalid) phase = 2;
          else n++;
        end
        default: begin
          mem_gnt    = 1'b0;
          mem_rvalid = 1'($urandom_range(0, 1));
          mem_rdata  = $urandom;
        end
      endcase
      @(posedge clk); #1;
    end
    lsu_valid  = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    check("latency", 32'(lat), 32'(lat_exp));
    check("busy_during", 32'(busy_ok), 32'd1);
    if (lat > 0) check("busy_at_end", 32'(lsu_busy), 32'(legal));
  endtask

  task automatic reset_in_wait();
    logic      legal, saw_done;
    bus_exp_t  b;
    resp_exp_t r;
    model(1'b0, 3'b010, 32'h3000, 32'h0, 32'h0, legal, b, r);
    bus_q.push_back(b);
    @(posedge clk); #1;
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h3000;
    @(posedge clk); #1;
    lsu_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    check("wait_busy", 32'(lsu_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_ctrl", {27'h0, mem_req, mem_we, lsu_busy, lsu_done, lsu_err}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_be", 32'(mem_be), 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_rdata", lsu_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (lsu_done || lsu_busy || mem_req) saw_done = 1'b1;
    end
    mem_rvalid = 1'b0;
    check("no_activity_after_rst", 32'(saw_done), 32'd0);
    check("rdata_after_rst", lsu_rdata, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'b0; lsu_addr = '0; lsu_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("reset_ctrl", {27'h0, mem_req, mem_we, lsu_busy, lsu_done, lsu_err}, 32'h0);
    check("reset_addr", mem_addr, 32'h0);
    check("reset_be", 32'(mem_be), 32'h0);
    check("reset_wdata", mem_wdata, 32'h0);
    check("reset_rdata", lsu_rdata, 32'h0);

    access(1'b1, 3'b010, 32'h1000, 32'hDEAD_BEEF, 32'h0, 0, 0);
    access(1'b1, 3'b000, 32'h1003, 32'h0000_00A5, 32'h0, 0, 0);
    access(1'b0, 3'b000, 32'h2001, 32'h0, 32'h1234_8056, 0, 0);
    check("lb_const", lsu_rdata, 32'hFFFF_FF80);
    access(1'b0, 3'b100, 32'h2001, 32'h0, 32'h1234_8056, 0, 0);
    check("lbu_const", lsu_rdata, 32'h0000_0080);
    access(1'b0, 3'b101, 32'h2002, 32'h0, 32'h1234_8056, 3, 2);
    check("lhu_const", lsu_rdata, 32'h0000_1234);
    access(1'b0, 3'b010, 32'h2002, 32'h0, 32'hA1B2_C3D4, 0, 0);
    access(1'b0, 3'b011, 32'h2000, 32'h0, 32'h0, 0, 0);
    access(1'b1, 3'b001, 32'h4003, 32'h0000_BEEF, 32'h0, 1, 0);
    reset_in_wait();

    for (int i = 0; i < 300; i++) begin
      access(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
    end
    repeat (3) @(posedge clk);
    check("queues_drained", 32'(bus_q.size() + resp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
